// File: rtl/instr_stream_loader.sv
// Instruction-load transmitter: buffers a small program, streams it into the CPU one word per
// clock, pulses the CPU reset for one cycle, then releases the CPU to run the loaded program.
module instr_stream_loader #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              start,
   output logic              LoadInstructions,
   output logic [DATA_W-1:0] Instruction,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done
);

   localparam int unsigned     LenW     = ADDR_W + 1;
   localparam logic [LenW-1:0] DepthLen = LenW'(DEPTH);

   typedef enum logic [1:0] {
      StHeld,
      StStream,
      StFlush,
      StRun
   } state_e;

   state_e              state_q, state_d;
   logic [LenW-1:0]     idx_q, idx_d;
   logic [LenW-1:0]     len_q, len_d;
   logic                load_q, load_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic                cpu_rst_q, cpu_rst_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                idle;
   logic                accept;
   logic                wr_en;
   logic [LenW-1:0]     len_clamped;
   logic [DATA_W-1:0]   rd_word;

   assign idle        = (state_q == StHeld) || (state_q == StRun);
   assign accept      = idle && start && (prog_len != '0);
   assign len_clamped = (prog_len > DepthLen) ? DepthLen : prog_len;
   assign wr_en       = prog_we && idle && ({1'b0, prog_addr} < DepthLen);
   assign rd_word     = mem_q[idx_q[ADDR_W-1:0]];

   // Program buffer survives block reset so a reload can reuse it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      load_d    = load_q;
      instr_d   = instr_q;
      cpu_rst_d = cpu_rst_q;
      busy_d    = busy_q;
      done_d    = done_q;

      unique case (state_q)
         StHeld, StRun: begin
            if (accept) begin
               state_d   = StStream;
               idx_d     = '0;
               len_d     = len_clamped;
               load_d    = 1'b0;
               instr_d   = '0;
               cpu_rst_d = 1'b0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
            end
         end
         StStream: begin
            if (idx_q < len_q) begin
               load_d  = 1'b1;
               instr_d = rd_word;
               idx_d   = idx_q + LenW'(1);
            end else begin
               state_d   = StFlush;
               load_d    = 1'b0;
               instr_d   = '0;
               cpu_rst_d = 1'b1;
            end
         end
         StFlush: begin
            state_d   = StRun;
            cpu_rst_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
         end
         default: begin
            state_d = StHeld;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q   <= StHeld;
         idx_q     <= '0;
         len_q     <= '0;
         load_q    <= 1'b0;
         instr_q   <= '0;
         cpu_rst_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         load_q    <= load_d;
         instr_q   <= instr_d;
         cpu_rst_q <= cpu_rst_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign LoadInstructions = load_q;
   assign Instruction      = instr_q;
   assign cpu_reset        = cpu_rst_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed bench for instr_stream_loader: load, clamp, ignore, mid-stream reset and reload cases.
module tb_instr_stream_loader;

   logic        clk;
   logic        Reset;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [31:0] prog_data;
   logic [4:0]  prog_len;
   logic        start;
   logic        LoadInstructions;
   logic [31:0] Instruction;
   logic        cpu_reset;
   logic        busy;
   logic        done;

   logic [31:0] exp_mem [16];
   int          n_chk;
   int          n_err;

   instr_stream_loader #(
      .DATA_W(32),
      .ADDR_W(4),
      .DEPTH (16)
   ) dut (
      .clk             (clk),
      .Reset           (Reset),
      .prog_we         (prog_we),
      .prog_addr       (prog_addr),
      .prog_data       (prog_data),
      .prog_len        (prog_len),
      .start           (start),
      .LoadInstructions(LoadInstructions),
      .Instruction     (Instruction),
      .cpu_reset       (cpu_reset),
      .busy            (busy),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [3:0] addr, input logic [31:0] data);
      prog_we   = 1'b1;
      prog_addr = addr;
      prog_data = data;
      tick();
      prog_we   = 1'b0;
      exp_mem[addr] = data;
   endtask

   task automatic start_seq(input logic [4:0] len);
      prog_len = len;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Checks n stream cycles, the flush cycle and the first run cycle.
   task automatic stream_check(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         tick();
         chk($sformatf("%s load[%0d]", tag, k), {31'b0, LoadInstructions}, 32'd1);
         chk($sformatf("%s instr[%0d]", tag, k), Instruction, exp_mem[k]);
         chk($sformatf("%s cpurst[%0d]", tag, k), {31'b0, cpu_reset}, 32'd0);
         chk($sformatf("%s busy[%0d]", tag, k), {31'b0, busy}, 32'd1);
         chk($sformatf("%s done[%0d]", tag, k), {31'b0, done}, 32'd0);
      end
      tick();
      chk({tag, " flush load"}, {31'b0, LoadInstructions}, 32'd0);
      chk({tag, " flush instr"}, Instruction, 32'd0);
      chk({tag, " flush cpurst"}, {31'b0, cpu_reset}, 32'd1);
      chk({tag, " flush busy"}, {31'b0, busy}, 32'd1);
      tick();
      chk({tag, " run done"}, {31'b0, done}, 32'd1);
      chk({tag, " run cpurst"}, {31'b0, cpu_reset}, 32'd0);
      chk({tag, " run busy"}, {31'b0, busy}, 32'd0);
      chk({tag, " run load"}, {31'b0, LoadInstructions}, 32'd0);
   endtask

   initial begin
      n_chk     = 0;
      n_err     = 0;
      Reset     = 1'b1;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      prog_len  = '0;
      start     = 1'b0;
      tick();
      tick();

      chk("rst cpurst", {31'b0, cpu_reset}, 32'd1);
      chk("rst load", {31'b0, LoadInstructions}, 32'd0);
      chk("rst instr", Instruction, 32'd0);
      chk("rst busy", {31'b0, busy}, 32'd0);
      chk("rst done", {31'b0, done}, 32'd0);
      Reset = 1'b0;

      // Basic three-word load
      for (int i = 0; i < 16; i++) write_word(4'(i), 32'hC0DE_0000 + i);
      write_word(4'd0, 32'h2001_01A7);
      write_word(4'd1, 32'h2002_005C);
      write_word(4'd2, 32'h2003_000D);
      chk("held cpurst", {31'b0, cpu_reset}, 32'd1);
      start_seq(5'd3);
      stream_check(3, "t2");

      // prog_len beyond DEPTH clamps to 16 words
      start_seq(5'd20);
      stream_check(16, "t3");

      // prog_len == 0 is ignored from RUN
      prog_len = 5'd0;
      start    = 1'b1;
      tick();
      tick();
      start    = 1'b0;
      chk("len0 done", {31'b0, done}, 32'd1);
      chk("len0 busy", {31'b0, busy}, 32'd0);
      chk("len0 load", {31'b0, LoadInstructions}, 32'd0);

      // start and write during STREAM are ignored
      start_seq(5'd4);
      tick();
      chk("ign load0", {31'b0, LoadInstructions}, 32'd1);
      chk("ign instr0", Instruction, exp_mem[0]);
      prog_len  = 5'd3;
      start     = 1'b1;
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = 32'hDEAD_BEEF;
      for (int k = 1; k < 4; k++) begin
         tick();
         start   = 1'b0;
         prog_we = 1'b0;
         chk($sformatf("ign load[%0d]", k), {31'b0, LoadInstructions}, 32'd1);
         chk($sformatf("ign instr[%0d]", k), Instruction, exp_mem[k]);
      end
      tick();
      chk("ign flush cpurst", {31'b0, cpu_reset}, 32'd1);
      tick();
      chk("ign run done", {31'b0, done}, 32'd1);

      // Reset on the second stream cycle, then restart from buf[0]
      start_seq(5'd3);
      tick();
      chk("mr instr0", Instruction, exp_mem[0]);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("mr load", {31'b0, LoadInstructions}, 32'd0);
      chk("mr cpurst", {31'b0, cpu_reset}, 32'd1);
      chk("mr busy", {31'b0, busy}, 32'd0);
      chk("mr done", {31'b0, done}, 32'd0);
      chk("mr instr", Instruction, 32'd0);
      tick();
      chk("mr held load", {31'b0, LoadInstructions}, 32'd0);
      start_seq(5'd3);
      stream_check(3, "t5");

      // Reload from RUN: rewrite slot 1, plus a write to slot 0 coincident with start
      write_word(4'd1, 32'h0000_0000);
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = 32'h0BAD_F00D;
      exp_mem[0] = 32'h0BAD_F00D;
      start_seq(5'd3);
      prog_we   = 1'b0;
      stream_check(3, "t6");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
